// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam int unsigned ILEN_BYTES     = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-2 FIFO of fetch entries with flush and occupancy count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  wdata_i,
  input  logic          pop_i,
  output fetch_entry_t  rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;
  logic          do_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  // a pop frees the head slot, so a full FIFO may still take a push that cycle
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, credit-limited word fetch, in-order buffer to decode
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          fault_push_q, fault_push_d;

  logic          redirect_misaligned;
  logic          req_accept;
  logic          rsp_keep;
  logic          credit_ok;
  logic          buf_push, buf_empty, buf_full;
  logic          pcq_empty, pcq_full;
  logic [CW-1:0] buf_count, pcq_count;
  fetch_entry_t  buf_wdata, buf_rdata, pcq_wdata, pcq_rdata;
  logic          unused_sigs;

  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign req_accept          = imem_req_valid && imem_req_ready;
  assign rsp_keep            = imem_rsp_valid && (drop_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid)      state_d = redirect_misaligned ? FAULT : FETCH;
    else if (state_q == BOOT) state_d = FETCH;
  end

  // dropped in-flight requests still hold a credit until their response returns
  always_comb begin
    credit_ok      = (({1'b0, inflight_q} + {1'b0, buf_count}) < DEPTH_W);
    imem_req_valid = (state_q == FETCH) && !redirect_valid && credit_ok;
  end

  always_comb begin
    pc_d         = pc_q;
    inflight_d   = inflight_q;
    drop_d       = drop_q;
    fault_push_d = redirect_valid && redirect_misaligned;
    if (req_accept)     inflight_d = inflight_d + 1'b1;
    if (imem_rsp_valid) inflight_d = inflight_d - 1'b1;
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      drop_d = inflight_d;
    end else begin
      if (req_accept) pc_d = pc_q + 32'(ILEN_BYTES);
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      inflight_q   <= '0;
      drop_q       <= '0;
      fault_push_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      fault_push_q <= fault_push_d;
    end
  end

  // in FAULT every returning response is a drop, so the marker never collides with data
  assign buf_push  = !redirect_valid && (fault_push_q || rsp_keep);
  assign buf_wdata = fault_push_q ? '{pc: pc_q, instr: 32'h0, fault: 1'b1}
                                  : '{pc: pcq_rdata.pc, instr: imem_rsp_data, fault: 1'b0};
  assign pcq_wdata = '{pc: pc_q, instr: 32'h0, fault: 1'b0};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (buf_push),
    .wdata_i (buf_wdata),
    .pop_i   (if_valid && if_ready),
    .rdata_o (buf_rdata),
    .empty_o (buf_empty),
    .full_o  (buf_full),
    .count_o (buf_count)
  );

  // never flushed: dropped responses must still retire their PC slot
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pcq (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (1'b0),
    .push_i  (req_accept),
    .wdata_i (pcq_wdata),
    .pop_i   (imem_rsp_valid),
    .rdata_o (pcq_rdata),
    .empty_o (pcq_empty),
    .full_o  (pcq_full),
    .count_o (pcq_count)
  );

  assign unused_sigs = ^{pcq_rdata.instr, pcq_rdata.fault, pcq_empty, pcq_full, pcq_count, buf_full};

  assign imem_req_addr = pc_q;
  assign if_valid      = !buf_empty;
  assign if_pc         = if_valid ? buf_rdata.pc    : 32'h0;
  assign if_instr      = if_valid ? buf_rdata.instr : 32'h0;
  assign if_fault      = if_valid && buf_rdata.fault;

  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench with randomized memory, decode and redirects
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready, if_fault;
  logic [31:0] if_instr, if_pc;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_fault       (if_fault)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } exp_t;
  typedef struct { int due; logic [31:0] data; } mrsp_t;

  exp_t        exp_q[$];
  mrsp_t       mem_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          rdy_pct = 100;
  int          acc_cnt = 0;
  logic [31:0] exp_req_pc = RST_PC;
  logic        no_req = 1'b0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // expected decode stream after a restart at t: sequential words, or a single fault marker
  function automatic void model_set(input logic [31:0] t);
    exp_t e;
    exp_q.delete();
    exp_req_pc = t;
    no_req     = (t[1:0] != 2'b00);
    if (no_req) begin
      e.pc = t; e.instr = 32'h0; e.fault = 1'b1;
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < 200; i++) begin
        e.pc = t + 32'(4 * i); e.instr = mem_word(e.pc); e.fault = 1'b0;
        exp_q.push_back(e);
      end
    end
  endfunction

  // memory: latency lat, random ready, strictly in-order responses
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        mem_q.delete();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
      end else begin
        imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_q[0].data;
          mem_q.delete(0);
        end else begin
          imem_rsp_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    mrsp_t m;
    exp_t  e;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        m.due = cyc + lat; m.data = mem_word(imem_req_addr);
        mem_q.push_back(m);
        acc_cnt++;
      end
      if (redirect_valid) begin
        chk("req_withdrawn_on_redirect", 32'(imem_req_valid), 32'h0);
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("req_hold_valid", 32'(imem_req_valid), 32'h1);
          chk("req_hold_addr", imem_req_addr, hold_addr);
        end
        if (no_req) chk("no_req_in_fault", 32'(imem_req_valid), 32'h0);
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", imem_req_addr, exp_req_pc);
          exp_req_pc = exp_req_pc + 32'd4;
        end
        hold_pend = imem_req_valid && !imem_req_ready;
        hold_addr = imem_req_addr;
        if (if_valid && if_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got pc 0x%08h expected no entry", if_pc);
          end else begin
            e = exp_q.pop_front();
            chk("if_pc", if_pc, e.pc);
            chk("if_instr", if_instr, e.instr);
            chk("if_fault", 32'(if_fault), 32'(e.fault));
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'h0);
    chk({tag, "_if_instr"}, if_instr, 32'h0);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
    chk({tag, "_if_fault"}, 32'(if_fault), 32'h0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] t);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = t;
    model_set(t);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    int          first;
    int          acc0;
    logic        prev_r;
    logic [31:0] r, t;
    rst_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(3);
    @(negedge clk);
    check_reset_vals("reset");

    @(posedge clk); #1;
    rst_n = 1'b1; if_ready = 1'b1;
    model_set(RST_PC);
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (if_valid) begin first = k; break; end
    end
    chk("first_valid_latency", 32'(first), 32'd3);
    step(12);

    @(posedge clk); #1; if_ready = 1'b0;
    do_redirect(32'h0000_0040);
    acc0 = acc_cnt;
    step(10);
    @(negedge clk);
    chk("credit_accepts", 32'(acc_cnt - acc0), 32'd2);
    chk("credit_req_low", 32'(imem_req_valid), 32'h0);
    chk("full_head_valid", 32'(if_valid), 32'h1);
    chk("full_head_pc", if_pc, 32'h0000_0040);
    @(posedge clk); #1; if_ready = 1'b1;
    step(10);

    lat = 3;
    step(10);
    do_redirect(32'h0000_0100);
    step(20);

    lat = 1;
    @(posedge clk); #1; if_ready = 1'b0;
    do_redirect(32'h0000_0102);
    step(4);
    @(negedge clk);
    chk("fault_held_valid", 32'(if_valid), 32'h1);
    chk("fault_held_flag", 32'(if_fault), 32'h1);
    chk("fault_held_pc", if_pc, 32'h0000_0102);
    chk("fault_held_instr", if_instr, 32'h0);
    @(posedge clk); #1; if_ready = 1'b1;
    step(6);
    @(negedge clk);
    chk("fault_consumed", 32'(exp_q.size()), 32'h0);
    chk("fault_single_entry", 32'(if_valid), 32'h0);
    do_redirect(32'h0000_0200);
    step(15);

    do_redirect(32'hFFFF_FFF4);
    step(20);

    rdy_pct = 70;
    prev_r  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if_ready = ($urandom_range(0, 3) != 0);
      if (!prev_r && $urandom_range(0, 24) == 0) begin
        r = $urandom();
        t = ($urandom_range(0, 5) == 0) ? {r[31:2], 1'b1, r[0]} : {r[31:2], 2'b00};
        lat = $urandom_range(1, 3);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        model_set(t);
        prev_r = 1'b1;
      end else begin
        redirect_valid = 1'b0;
        prev_r = 1'b0;
      end
    end
    @(posedge clk); #1; redirect_valid = 1'b0;

    rdy_pct = 100; lat = 3; if_ready = 1'b0;
    do_redirect(32'h0000_0300);
    step(6);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check_reset_vals("midreset");
    step(2);
    @(posedge clk); #1;
    rst_n = 1'b1; lat = 1; if_ready = 1'b1;
    model_set(RST_PC);
    step(20);
    @(negedge clk);
    chk("restart_progress", 32'(exp_q.size() < 200), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
